// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line in, received byte and status strobes out
interface uart_receiver_if;
    import uart_pkg::*;
    logic                 RxD;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_error;
    logic                 busy;
    modport master (output RxD, input rx_data, rx_valid, frame_error, busy);
    modport slave  (input RxD, output rx_data, rx_valid, frame_error, busy);
endinterface

// File: rtl/uart_receiver_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;
    // shift the async input through two flops; reset to the line's idle level
    always_ff @(posedge clk)
        r_sync <= reset ? {2{RST_VAL}} : {r_sync[0], i_d};
    assign o_q = r_sync[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling, stop-bit check and break hold-off
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input logic           clk,
    input logic           reset,
    uart_receiver_if.slave rx
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state, w_state_nxt;
    logic [CW-1:0]        r_ctr, w_ctr_nxt;
    logic [BW-1:0]        r_bitidx, w_bitidx_nxt;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_ferr, w_ferr_nxt;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx.RxD),
        .o_q   (w_rx_s)
    );

    // state, counters, shift register and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ctr    <= '0;
            r_bitidx <= '0;
            r_shreg  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ctr    <= w_ctr_nxt;
            r_bitidx <= w_bitidx_nxt;
            r_shreg  <= w_shreg_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_ferr   <= w_ferr_nxt;
        end
    end

    // next-state logic: counter clears on every state change and on every data sample
    always_comb begin
        w_state_nxt  = r_state;
        w_ctr_nxt    = r_ctr + 1'b1;
        w_bitidx_nxt = r_bitidx;
        w_shreg_nxt  = r_shreg;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ctr_nxt = '0;
                if (!w_rx_s) w_state_nxt = START;
            end
            START: begin
                if (r_ctr == HALF_M1) begin
                    w_ctr_nxt    = '0;
                    w_bitidx_nxt = '0;
                    w_state_nxt  = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_ctr == FULL_M1) begin
                    w_ctr_nxt    = '0;
                    w_shreg_nxt  = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                    w_bitidx_nxt = r_bitidx + 1'b1;
                    if (r_bitidx == LAST_BIT) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (r_ctr == FULL_M1) begin
                    w_ctr_nxt   = '0;
                    w_data_nxt  = w_rx_s ? r_shreg : r_data;
                    w_valid_nxt = w_rx_s;
                    w_ferr_nxt  = !w_rx_s;
                    w_state_nxt = w_rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                w_ctr_nxt = '0;
                if (w_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign rx.rx_data     = r_data;
    assign rx.rx_valid    = r_valid;
    assign rx.frame_error = r_ferr;
    assign rx.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level checks of the UART receiver against a byte/strobe model
module tb_uart_receiver;
    localparam int C = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    byte unsigned got_q[$];
    int fcnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_bits;
        int         exp_nv;
        int         exp_nf;
        logic [7:0] exp_rx;
    } vec_t;

    uart_receiver_if bus ();

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // record strobes away from the clock edge; the two strobes must never coincide
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) got_q.push_back(bus.rx_data);
            if (bus.frame_error) fcnt++;
            if (bus.rx_valid || bus.frame_error)
                chk("strobe_exclusive", {31'd0, bus.rx_valid & bus.frame_error}, 0);
        end
    end

    task automatic drive(input logic v, input int n);
        bus.RxD = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(d[i], C);
        drive(stop, C);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.busy && k < 4 * C) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, " idle_timeout"}, {31'd0, bus.busy}, 0);
    endtask

    task automatic expect_out(input string name, input int nv, input logic [7:0] last, input int nf);
        chk({name, " valid_count"}, got_q.size(), nv);
        chk({name, " ferr_count"}, fcnt, nf);
        chk({name, " rx_data"}, {24'd0, bus.rx_data}, {24'd0, last});
        chk({name, " busy"}, {31'd0, bus.busy}, 0);
        got_q.delete();
        fcnt = 0;
    endtask

    initial begin
        vec_t tbl[4];
        logic [7:0] last;
        logic [7:0] d;
        logic stop;
        tbl[0] = '{8'hA5, 1'b1, 0, 1, 0, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 3, 0, 1, 8'hA5};
        tbl[2] = '{8'h81, 1'b1, 0, 1, 0, 8'h81};
        tbl[3] = '{8'h7E, 1'b0, 0, 0, 1, 8'h81};
        bus.RxD = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset rx_data", {24'd0, bus.rx_data}, 0);
        chk("reset rx_valid", {31'd0, bus.rx_valid}, 0);
        chk("reset frame_error", {31'd0, bus.frame_error}, 0);
        chk("reset busy", {31'd0, bus.busy}, 0);
        drive(1'b1, C);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].data, tbl[i].stop);
            if (!tbl[i].stop) begin
                drive(1'b0, tbl[i].low_bits * C);
                chk($sformatf("tbl%0d break_hold busy", i), {31'd0, bus.busy}, 1);
            end
            drive(1'b1, C);
            wait_idle($sformatf("tbl%0d", i));
            expect_out($sformatf("tbl%0d", i), tbl[i].exp_nv, tbl[i].exp_rx, tbl[i].exp_nf);
        end

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        wait_idle("b2b");
        chk("b2b first", {24'd0, got_q.size() > 0 ? got_q[0] : 8'hEE}, 8'h00);
        chk("b2b second", {24'd0, got_q.size() > 1 ? got_q[1] : 8'hEE}, 8'hFF);
        expect_out("b2b", 2, 8'hFF, 0);

        drive(1'b0, C / 4);
        chk("glitch detected busy", {31'd0, bus.busy}, 1);
        drive(1'b1, 2 * C);
        expect_out("glitch", 0, 8'hFF, 0);

        d = 8'h55;
        drive(1'b0, C);
        for (int i = 0; i < 4; i++) drive(d[i], C);
        drive(d[4], C / 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset rx_data", {24'd0, bus.rx_data}, 0);
        chk("midreset rx_valid", {31'd0, bus.rx_valid}, 0);
        chk("midreset frame_error", {31'd0, bus.frame_error}, 0);
        chk("midreset busy", {31'd0, bus.busy}, 0);
        got_q.delete();
        fcnt = 0;
        drive(1'b1, 2 * C);
        expect_out("midreset quiet", 0, 8'h00, 0);
        send(8'h81, 1'b1);
        wait_idle("after_reset");
        expect_out("after_reset", 1, 8'h81, 0);

        last = 8'h81;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            if (stop) last = d;
            drive(1'b1, $urandom_range(0, 3));
            send(d, stop);
            if (!stop) drive(1'b1, C);
            wait_idle($sformatf("rand%0d", i));
            expect_out($sformatf("rand%0d", i), stop ? 1 : 0, last, stop ? 0 : 1);
        end

        for (int i = 0; i < 256; i++) begin
            send(8'(i), 1'b1);
            chk($sformatf("sweep %0d", i), {24'd0, got_q.size() > 0 ? got_q.pop_front() : 8'(i ^ 1)}, i);
        end
        wait_idle("sweep");
        expect_out("sweep", 0, 8'hFF, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
